// File: rtl/jtcps1_gfx_bankmap.sv
// Runtime-programmable GFX bank mapper: (layer, tile code) -> bank offset/mask, 2-cycle pipeline.
// Optional miss statistics counter enabled by defining JTCPS1_GFX_BANKMAP_STATS_EN.
module jtcps1_gfx_bankmap #(
  parameter int NBANKS  = 4,
  parameter int BW      = 4,
  parameter int NRANGES = 8,
  parameter int CODEW   = 10
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        enable,
  input  logic [NBANKS*BW-1:0]                        bank_offset,
  input  logic [NBANKS*BW-1:0]                        bank_mask,
  input  logic                                        cfg_we,
  input  logic [$clog2(NRANGES)-1:0]                  cfg_addr,
  input  logic [5+2*CODEW+$clog2(NBANKS)-1:0]         cfg_data,
  input  logic                                        cfg_clr,
  input  logic                                        req,
  input  logic [2:0]                                  layer,
  input  logic [CODEW-1:0]                            cin,
  output logic                                        ack,
  output logic [BW-1:0]                               offset,
  output logic [BW-1:0]                               mask,
  output logic                                        unmapped
`ifdef JTCPS1_GFX_BANKMAP_STATS_EN
  ,
  output logic [15:0]                                 miss_cnt,
  input  logic                                        miss_clr
`endif
);

  localparam int BSEL = $clog2(NBANKS);
  localparam int CFGW = 5 + 2*CODEW + BSEL;

  logic [4:0]       cfg_en;
  logic [CODEW-1:0] cfg_lo;
  logic [CODEW-1:0] cfg_hi;
  logic [BSEL-1:0]  cfg_bank;

  assign cfg_en   = cfg_data[CFGW-1 -: 5];
  assign cfg_lo   = cfg_data[BSEL+2*CODEW-1 -: CODEW];
  assign cfg_hi   = cfg_data[BSEL+CODEW-1 -: CODEW];
  assign cfg_bank = cfg_data[BSEL-1:0];

  // range table
  logic [NRANGES-1:0] valid_q, valid_d;
  logic [4:0]         en_q   [NRANGES];
  logic [4:0]         en_d   [NRANGES];
  logic [CODEW-1:0]   lo_q   [NRANGES];
  logic [CODEW-1:0]   lo_d   [NRANGES];
  logic [CODEW-1:0]   hi_q   [NRANGES];
  logic [CODEW-1:0]   hi_d   [NRANGES];
  logic [BSEL-1:0]    ebank_q[NRANGES];
  logic [BSEL-1:0]    ebank_d[NRANGES];

  always_comb begin
    valid_d = valid_q;
    en_d    = en_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    ebank_d = ebank_q;
    if (cfg_we) begin
      valid_d[cfg_addr] = 1'b1;
      en_d[cfg_addr]    = cfg_en;
      lo_d[cfg_addr]    = cfg_lo;
      hi_d[cfg_addr]    = cfg_hi;
      ebank_d[cfg_addr] = cfg_bank;
    end
    if (cfg_clr) valid_d = '0;
  end

  // entries pointing past the last bank can only exist for non-power-of-2 NBANKS
  logic [NRANGES-1:0] bank_ok;
  generate
    if ((1 << BSEL) == NBANKS) begin : g_pow2
      assign bank_ok = '1;
    end else begin : g_npow2
      always_comb begin
        bank_ok = '0;
        for (int i = 0; i < NRANGES; i++) bank_ok[i] = (32'(ebank_q[i]) < NBANKS);
      end
    end
  endgenerate

  // stage 1: compare
  logic [4:0]         layer_oh;
  logic [NRANGES-1:0] hit_q, hit_d;
  logic [BSEL-1:0]    s1_bank_q, s1_bank_d;
  logic               acc_q, acc_d;

  always_comb begin
    layer_oh  = 5'd1 << layer;
    hit_d     = '0;
    s1_bank_d = '0;
    acc_d     = req && enable;
    for (int i = 0; i < NRANGES; i++)
      hit_d[i] = valid_q[i] && (|(en_q[i] & layer_oh)) && bank_ok[i] &&
                 (lo_q[i] <= cin) && (cin <= hi_q[i]);
    // winner's bank is captured now so a later table write cannot alter an in-flight lookup
    for (int i = NRANGES-1; i >= 0; i--)
      if (hit_d[i]) s1_bank_d = ebank_q[i];
  end

  // stage 2: select
  logic          ack_q, ack_d;
  logic [BW-1:0] offset_q, offset_d;
  logic [BW-1:0] mask_q, mask_d;
  logic          unmapped_q, unmapped_d;
  logic [BW-1:0] sel_off, sel_mask;

  always_comb begin
    sel_off  = '0;
    sel_mask = '0;
    for (int n = 0; n < NBANKS; n++) begin
      if (s1_bank_q == BSEL'(n)) begin
        sel_off  = bank_offset[n*BW +: BW];
        sel_mask = bank_mask[n*BW +: BW];
      end
    end
    ack_d      = acc_q;
    offset_d   = offset_q;
    mask_d     = mask_q;
    unmapped_d = unmapped_q;
    if (acc_q) begin
      if (|hit_q) begin
        offset_d   = sel_off;
        mask_d     = sel_mask;
        unmapped_d = 1'b0;
      end else begin
        offset_d   = '0;
        mask_d     = '1;
        unmapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= '0;
      hit_q      <= '0;
      s1_bank_q  <= '0;
      acc_q      <= 1'b0;
      ack_q      <= 1'b0;
      offset_q   <= '0;
      mask_q     <= '0;
      unmapped_q <= 1'b1;
    end else begin
      valid_q    <= valid_d;
      hit_q      <= hit_d;
      s1_bank_q  <= s1_bank_d;
      acc_q      <= acc_d;
      ack_q      <= ack_d;
      offset_q   <= offset_d;
      mask_q     <= mask_d;
      unmapped_q <= unmapped_d;
    end
  end

  // entry fields carry no reset; the valid bits alone qualify them
  always_ff @(posedge clk) begin
    en_q    <= en_d;
    lo_q    <= lo_d;
    hi_q    <= hi_d;
    ebank_q <= ebank_d;
  end

  assign ack      = ack_q;
  assign offset   = offset_q;
  assign mask     = mask_q;
  assign unmapped = unmapped_q;

`ifdef JTCPS1_GFX_BANKMAP_STATS_EN
  logic [15:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    miss_cnt_d = miss_cnt_q;
    if (miss_clr)
      miss_cnt_d = '0;
    else if (ack_d && unmapped_d && (miss_cnt_q != 16'hFFFF))
      miss_cnt_d = miss_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) miss_cnt_q <= '0;
    else     miss_cnt_q <= miss_cnt_d;
  end

  assign miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_jtcps1_gfx_bankmap.sv
// Directed testbench for jtcps1_gfx_bankmap; exercises the miss counter when
// JTCPS1_GFX_BANKMAP_STATS_EN is defined.
module tb_jtcps1_gfx_bankmap;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] bank_offset;
  logic [15:0] bank_mask;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [26:0] cfg_data;
  logic        cfg_clr;
  logic        req;
  logic [2:0]  layer;
  logic [9:0]  cin;
  logic        ack;
  logic [3:0]  offset;
  logic [3:0]  mask;
  logic        unmapped;
`ifdef JTCPS1_GFX_BANKMAP_STATS_EN
  logic [15:0] miss_cnt;
  logic        miss_clr;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtcps1_gfx_bankmap dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .bank_offset (bank_offset),
    .bank_mask   (bank_mask),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .cfg_clr     (cfg_clr),
    .req         (req),
    .layer       (layer),
    .cin         (cin),
    .ack         (ack),
    .offset      (offset),
    .mask        (mask),
    .unmapped    (unmapped)
`ifdef JTCPS1_GFX_BANKMAP_STATS_EN
    ,
    .miss_cnt    (miss_cnt),
    .miss_clr    (miss_clr)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] res();
    return {6'b0, ack, offset, mask, unmapped};
  endfunction

  function automatic logic [15:0] exp_r(input logic a, input logic [3:0] o,
                                        input logic [3:0] m, input logic u);
    return {6'b0, a, o, m, u};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [4:0] en, input logic [9:0] lo,
                    input logic [9:0] hi, input logic [1:0] b);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = {en, lo, hi, b};
    tick();
    cfg_we   = 1'b0;
  endtask

  task automatic look(input logic [2:0] l, input logic [9:0] c);
    layer = l;
    cin   = c;
    req   = 1'b1;
    tick();
    req   = 1'b0;
    tick();
  endtask

  logic [15:0] e;

  initial begin
    rst = 1'b1; enable = 1'b1; req = 1'b1; layer = 3'd1; cin = 10'h080;
    cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; cfg_clr = 1'b0;
    bank_offset = 16'h4321; bank_mask = 16'hFEDC;
`ifdef JTCPS1_GFX_BANKMAP_STATS_EN
    miss_clr = 1'b0;
`endif

    // reset held with req active
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_hold", res(), exp_r(0, 4'h0, 4'h0, 1));
    end
    rst = 1'b0;
    tick();
    chk("reset_release", res(), exp_r(0, 4'h0, 4'h0, 1));
    req = 1'b0;
    tick();
    chk("first_req_empty_table", res(), exp_r(1, 4'h0, 4'hF, 1));
    tick();
    chk("ack_pulse_ends", res(), exp_r(0, 4'h0, 4'hF, 1));

    // basic hit
    wr(3'd0, 5'b00010, 10'h000, 10'h0FF, 2'd1);
    look(3'd1, 10'h080);
    chk("basic_hit", res(), exp_r(1, 4'h2, 4'hD, 0));
    tick();
    chk("hold_after_ack", res(), exp_r(0, 4'h2, 4'hD, 0));
    look(3'd2, 10'h080);
    chk("basic_wrong_layer", res(), exp_r(1, 4'h0, 4'hF, 1));

    // priority
    wr(3'd5, 5'b11111, 10'h000, 10'h3FF, 2'd3);
    wr(3'd2, 5'b11111, 10'h100, 10'h1FF, 2'd0);
    look(3'd3, 10'h150);
    chk("prio_low_index", res(), exp_r(1, 4'h1, 4'hC, 0));
    look(3'd3, 10'h250);
    chk("prio_fallthrough", res(), exp_r(1, 4'h4, 4'hF, 0));
    look(3'd1, 10'h080);
    chk("prio_entry0", res(), exp_r(1, 4'h2, 4'hD, 0));

    // boundaries
    wr(3'd1, 5'b11111, 10'h3FF, 10'h3FF, 2'd2);
    look(3'd0, 10'h3FF);
    chk("single_code_hit", res(), exp_r(1, 4'h3, 4'hE, 0));
    look(3'd0, 10'h3FE);
    chk("single_code_miss", res(), exp_r(1, 4'h4, 4'hF, 0));
    wr(3'd3, 5'b11111, 10'h200, 10'h100, 2'd1);
    look(3'd4, 10'h200);
    chk("inverted_lo", res(), exp_r(1, 4'h4, 4'hF, 0));
    look(3'd4, 10'h150);
    chk("inverted_mid", res(), exp_r(1, 4'h1, 4'hC, 0));
    look(3'd5, 10'h080);
    chk("layer5_miss", res(), exp_r(1, 4'h0, 4'hF, 1));
    look(3'd7, 10'h3FF);
    chk("layer7_miss", res(), exp_r(1, 4'h0, 4'hF, 1));

    // enable gates requests
    enable = 1'b0;
    look(3'd1, 10'h080);
    chk("disabled_no_ack", res(), exp_r(0, 4'h0, 4'hF, 1));
    enable = 1'b1;

    // 16 back-to-back lookups
    layer = 3'd1;
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) begin
        req = 1'b1;
        cin = 10'(i * 'h40);
      end else begin
        req = 1'b0;
      end
      tick();
      if (i >= 1) begin
        if (i - 1 < 4)      e = exp_r(1, 4'h2, 4'hD, 0);
        else if (i - 1 < 8) e = exp_r(1, 4'h1, 4'hC, 0);
        else                e = exp_r(1, 4'h4, 4'hF, 0);
        chk($sformatf("stream_%0d", i - 1), res(), e);
      end
    end
    tick();
    chk("stream_end", res(), exp_r(0, 4'h4, 4'hF, 0));

    // write in the same cycle as request k
    layer = 3'd1; cin = 10'h080; req = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = {5'b00010, 10'h000, 10'h0FF, 2'd2};
    tick();
    cfg_we = 1'b0;
    tick();
    chk("hazard_old", res(), exp_r(1, 4'h2, 4'hD, 0));
    req = 1'b0;
    tick();
    chk("hazard_new", res(), exp_r(1, 4'h3, 4'hE, 0));

    // clear wins over a simultaneous write
    cfg_clr = 1'b1; cfg_we = 1'b1; cfg_addr = 3'd4;
    cfg_data = {5'b11111, 10'h000, 10'h3FF, 2'd0};
    tick();
    cfg_clr = 1'b0; cfg_we = 1'b0;
    look(3'd1, 10'h080);
    chk("clear_a", res(), exp_r(1, 4'h0, 4'hF, 1));
    look(3'd3, 10'h250);
    chk("clear_b", res(), exp_r(1, 4'h0, 4'hF, 1));
    look(3'd0, 10'h000);
    chk("clear_c", res(), exp_r(1, 4'h0, 4'hF, 1));

    // reset while a lookup is in flight
    wr(3'd0, 5'b11111, 10'h000, 10'h3FF, 2'd1);
    look(3'd1, 10'h080);
    chk("rewrite_hit", res(), exp_r(1, 4'h2, 4'hD, 0));
    req = 1'b1;
    tick();
    req = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midflight_rst", res(), exp_r(0, 4'h0, 4'h0, 1));
    tick();
    chk("midflight_no_ack1", res(), exp_r(0, 4'h0, 4'h0, 1));
    tick();
    chk("midflight_no_ack2", res(), exp_r(0, 4'h0, 4'h0, 1));

`ifdef JTCPS1_GFX_BANKMAP_STATS_EN
    chk("miss_cnt_reset", miss_cnt, 16'd0);
    layer = 3'd1; cin = 10'h080; req = 1'b1;
    tick(); tick(); tick();
    req = 1'b0;
    tick();
    chk("miss_cnt_3", miss_cnt, 16'd3);
    tick();
    chk("miss_cnt_hold", miss_cnt, 16'd3);
    miss_clr = 1'b1;
    tick();
    miss_clr = 1'b0;
    chk("miss_cnt_clr", miss_cnt, 16'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
